// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and flow controller for the 5-stage Y86 pipeline.
// It drives stall/bubble controls for the pipeline registers and set_cc.
// It covers load-use, ret, mispredicted jXX and exception propagation.
// A RUN/DRAIN/HALTED FSM freezes the pipe once a halt or fault retires.
// It also latches the terminating status and counts cycles.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the perf event counters.
// When the macro is undefined, the perf ports exist but are tied to zero.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic [1:0]       state,
  output logic [3:0]       exc_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] perf_lu_cnt,
  output logic [CNT_W-1:0] perf_mp_cnt,
  output logic [CNT_W-1:0] perf_ret_cnt
);

  // Instruction codes that the hazard logic cares about.
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_POPQ   = 4'd11;
  localparam logic [3:0] R_NONE   = 4'd15;
  localparam logic [3:0] S_AOK    = 4'd1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       exc_stat_q;
  logic [CNT_W-1:0] cycle_cnt_q;

  logic load_use;
  logic ret_in;
  logic mispred;
  logic m_exc;
  logic w_exc;

  // Hazard conditions, derived purely from the current pipeline register contents.
  always_comb begin
    load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
               (E_dstM != R_NONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_in   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispred  = (E_icode == I_JXX) && !e_Cnd;
    m_exc    = (m_stat != S_AOK);
    w_exc    = (W_stat != S_AOK);
  end

  // State register; a low rst_n at the edge always returns to RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and pipeline control outputs. The priority is reset flush,
  // then the HALTED freeze, then normal hazard handling.
  always_comb begin
    state_d  = state_q;
    F_stall  = load_use || ret_in;
    D_stall  = load_use;
    W_stall  = w_exc;
    D_bubble = mispred || (ret_in && !load_use);
    E_bubble = mispred || load_use;
    M_bubble = m_exc || w_exc;
    set_cc   = (E_icode == I_OPQ) && !m_exc && !w_exc;

    case (state_q)
      ST_RUN: begin
        if (w_exc) begin
          state_d = ST_HALTED;
        end else if (m_exc) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_exc) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_d  = ST_HALTED;
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        set_cc   = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // While reset is held, flush the whole pipe without freezing fetch.
    if (!rst_n) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      W_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      set_cc   = 1'b0;
    end
  end

  // Capture the status of the retiring instruction once, on entry to HALTED.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_stat_q <= S_AOK;
    end else if ((state_q != ST_HALTED) && (state_d == ST_HALTED)) begin
      exc_stat_q <= W_stat;
    end
  end

  // Free-running cycle counter that freezes once the machine has halted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
    end else if (state_q != ST_HALTED) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_lu_q;
  logic [CNT_W-1:0] perf_mp_q;
  logic [CNT_W-1:0] perf_ret_q;

  // Event counters. They only count while the pipe is live; a ret cycle that
  // is masked by a load-use stall is not counted as a ret bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lu_q  <= '0;
      perf_mp_q  <= '0;
      perf_ret_q <= '0;
    end else if (state_q != ST_HALTED) begin
      if (load_use) begin
        perf_lu_q <= perf_lu_q + CNT_ONE;
      end
      if (mispred) begin
        perf_mp_q <= perf_mp_q + CNT_ONE;
      end
      if (ret_in && !load_use) begin
        perf_ret_q <= perf_ret_q + CNT_ONE;
      end
    end
  end

  assign perf_lu_cnt  = perf_lu_q;
  assign perf_mp_cnt  = perf_mp_q;
  assign perf_ret_cnt = perf_ret_q;
`else
  assign perf_lu_cnt  = '0;
  assign perf_mp_cnt  = '0;
  assign perf_ret_cnt = '0;
`endif

  assign state     = state_q;
  assign exc_stat  = exc_stat_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with hand-computed expected values.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
  logic             e_Cnd;
  logic             F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc;
  logic [1:0]       state;
  logic [3:0]       exc_stat;
  logic [CNT_W-1:0] cycle_cnt, perf_lu_cnt, perf_mp_cnt, perf_ret_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  bit halted_exp = 0;
  logic [CNT_W-1:0] frozen_cnt;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc(set_cc), .state(state), .exc_stat(exc_stat), .cycle_cnt(cycle_cnt),
    .perf_lu_cnt(perf_lu_cnt), .perf_mp_cnt(perf_mp_cnt), .perf_ret_cnt(perf_ret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("  ok   %s = %0h", tag, got);
    end
  endtask

  // Packed view of the pipeline controls: {F_stall,D_stall,W_stall,D_bubble,E_bubble,M_bubble,set_cc}
  function automatic logic [6:0] ctl();
    return {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc};
  endfunction

  task automatic idle();
    D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1;
    d_srcA = 4'd15; d_srcB = 4'd15; E_dstM = 4'd15;
    e_Cnd = 1'b0; m_stat = 4'd1; W_stat = 4'd1;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, away from it.
  task automatic tick();
    if (!rst_n) exp_cnt = 0;
    else if (!halted_exp) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    E_icode = 4'd6;
    tick();
    tick();
    #1;
    // Reset flush: {F,D,W stall, D,E,M bubble, set_cc}
    check("rst_ctl", ctl(), 7'b000_111_0);
    check("rst_state", state, 2'd0);
    check("rst_exc", exc_stat, 4'd1);
    check("rst_cnt", cycle_cnt, 0);

    rst_n = 1'b1;
    #1;
    check("run_opq_ctl", ctl(), 7'b000_000_1);
    tick();
    check("cnt_first", cycle_cnt, exp_cnt);

    // Load-use via srcA with mrmovq: one cycle only
    idle(); E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3; #1;
    check("lu_srcA_ctl", ctl(), 7'b110_010_0);
    tick();
    idle(); #1;
    check("lu_clear_ctl", ctl(), 7'b000_000_0);
    // Load-use via srcB with popq
    E_icode = 4'd11; E_dstM = 4'd4; d_srcB = 4'd4; #1;
    check("lu_popq_srcB", ctl(), 7'b110_010_0);
    tick();
    // dstM = none never matches, even against src = none
    idle(); E_icode = 4'd5; #1;
    check("lu_none_ctl", ctl(), 7'b000_000_0);
    tick();
    idle(); E_icode = 4'd5; E_dstM = 4'd2; d_srcA = 4'd3; d_srcB = 4'd4; #1;
    check("lu_nomatch", ctl(), 7'b000_000_0);
    tick();

    // ret walking D -> E -> M
    idle(); D_icode = 4'd9; #1;
    check("ret_D_ctl", ctl(), 7'b100_100_0);
    tick();
    idle(); E_icode = 4'd9; #1;
    check("ret_E_ctl", ctl(), 7'b100_100_0);
    tick();
    idle(); M_icode = 4'd9; #1;
    check("ret_M_ctl", ctl(), 7'b100_100_0);
    tick();
    idle(); #1;
    check("ret_done_ctl", ctl(), 7'b000_000_0);
    tick();

    // Mispredicted jump and correctly predicted jump
    idle(); E_icode = 4'd7; e_Cnd = 1'b0; #1;
    check("mp_ctl", ctl(), 7'b000_110_0);
    tick();
    e_Cnd = 1'b1; #1;
    check("jmp_taken_ctl", ctl(), 7'b000_000_0);
    tick();

    // load-use together with ret: stall F/D, bubble E, no D bubble
    idle(); E_icode = 4'd5; E_dstM = 4'd3; d_srcB = 4'd3; D_icode = 4'd9; #1;
    check("lu_ret_ctl", ctl(), 7'b110_010_0);
    tick();
    // mispred together with ret
    idle(); E_icode = 4'd7; D_icode = 4'd9; #1;
    check("mp_ret_ctl", ctl(), 7'b100_110_0);
    tick();
    // Fourth load-use cycle
    idle(); E_icode = 4'd11; E_dstM = 4'd7; d_srcA = 4'd7; #1;
    check("lu4_ctl", ctl(), 7'b110_010_0);
    tick();

    // Fault in memory, then retiring in writeback
    idle(); E_icode = 4'd6; m_stat = 4'd3; #1;
    check("mexc_ctl", ctl(), 7'b000_001_0);
    check("mexc_state", state, 2'd0);
    tick();
    check("drain_state", state, 2'd1);
    m_stat = 4'd1; W_stat = 4'd3; #1;
    check("wexc_ctl", ctl(), 7'b001_001_0);
    tick();
    halted_exp = 1;
    check("halt_state", state, 2'd2);
    check("halt_exc", exc_stat, 4'd3);
    check("halt_cnt", cycle_cnt, exp_cnt);
    frozen_cnt = cycle_cnt;

    // Halted: frozen controls, sticky status, no counting of events
    idle(); E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3; D_icode = 4'd9; W_stat = 4'd4; #1;
    check("halted_ctl", ctl(), 7'b111_011_0);
    tick(); tick(); tick();
    idle(); E_icode = 4'd6; #1;
    check("halted_ctl2", ctl(), 7'b111_011_0);
    check("halted_sticky", state, 2'd2);
    check("halted_exc_keep", exc_stat, 4'd3);
    check("halted_cnt_frozen", cycle_cnt, frozen_cnt);

`ifdef PIPE_CTRL_PERF_EN
    check("perf_lu", perf_lu_cnt, 4);
    check("perf_mp", perf_mp_cnt, 2);
    check("perf_ret", perf_ret_cnt, 4);
`else
    check("perf_lu", perf_lu_cnt, 0);
    check("perf_mp", perf_mp_cnt, 0);
    check("perf_ret", perf_ret_cnt, 0);
`endif

    // Reset while HALTED
    rst_n = 1'b0; #1;
    check("rst_halt_ctl", ctl(), 7'b000_111_0);
    tick();
    halted_exp = 0;
    check("rst_halt_state", state, 2'd0);
    check("rst_halt_exc", exc_stat, 4'd1);
    check("rst_halt_cnt", cycle_cnt, 0);
    check("rst_perf_lu", perf_lu_cnt, 0);
    rst_n = 1'b1;

    // Direct RUN -> HALTED when writeback faults with no DRAIN stage
    idle(); W_stat = 4'd4; #1;
    check("w_direct_ctl", ctl(), 7'b001_001_0);
    tick();
    halted_exp = 1;
    check("w_direct_state", state, 2'd2);
    check("w_direct_exc", exc_stat, 4'd4);
    check("w_direct_cnt", cycle_cnt, exp_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
